// File: rtl/snoop_bus_arbiter_if.sv
// Bus bundle between the two snooping caches, the snoop broadcast and main memory.
// The arbiter connects through the master modport; the environment uses slave.
interface snoop_bus_arbiter_if #(
    parameter int unsigned ADDRESSBIT = 32,
    parameter int unsigned WORDSIZE   = 32,
    parameter int unsigned BLOCKBYTE  = 4
);
    localparam int unsigned LW = WORDSIZE * BLOCKBYTE;

    logic [1:0]              req;
    logic [1:0]              rw;
    logic [2*ADDRESSBIT-1:0] addr;
    logic [2*LW-1:0]         wdata;
    logic [1:0]              done;
    logic [LW-1:0]           rdata;
    logic                    memReq;
    logic                    memRW;
    logic [ADDRESSBIT-1:0]   memAddr;
    logic [LW-1:0]           memDataOut;
    logic [LW-1:0]           memDataIn;
    logic                    memSuccess;
    logic [3:0]              snoopAction;
    logic                    snoopProc;
    logic [ADDRESSBIT-1:0]   snoopAddr;
    logic [WORDSIZE-1:0]     snoopValue;

    modport master (
        input  req, rw, addr, wdata, memDataIn, memSuccess,
        output done, rdata, memReq, memRW, memAddr, memDataOut,
               snoopAction, snoopProc, snoopAddr, snoopValue
    );

    modport slave (
        output req, rw, addr, wdata, memDataIn, memSuccess,
        input  done, rdata, memReq, memRW, memAddr, memDataOut,
               snoopAction, snoopProc, snoopAddr, snoopValue
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Two-cache snoop bus arbiter: grant, snoop broadcast, memory block access, completion.
// Define SNOOP_RR_ARB_EN for round-robin arbitration; default is fixed priority to proc 0.
module snoop_bus_arbiter #(
    parameter int unsigned ADDRESSBIT = 32,
    parameter int unsigned WORDSIZE   = 32,
    parameter int unsigned BLOCKBYTE  = 4
) (
    input  logic                clk,
    input  logic                rst,
    snoop_bus_arbiter_if.master bus
);
    localparam int unsigned LW = WORDSIZE * BLOCKBYTE;

    typedef enum logic [1:0] {IDLE, SNOOP, MEM, RESP} state_e;

    state_e                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  rw_q, rw_d;
    logic [ADDRESSBIT-1:0] addr_q, addr_d;
    logic [LW-1:0]         wdata_q, wdata_d;

    logic [1:0]            done_q, done_d;
    logic [LW-1:0]         rdata_q, rdata_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_rw_q, mem_rw_d;
    logic [ADDRESSBIT-1:0] mem_addr_q, mem_addr_d;
    logic [LW-1:0]         mem_data_out_q, mem_data_out_d;
    logic [3:0]            snoop_action_q, snoop_action_d;
    logic                  snoop_proc_q, snoop_proc_d;
    logic [ADDRESSBIT-1:0] snoop_addr_q, snoop_addr_d;
    logic [WORDSIZE-1:0]   snoop_value_q, snoop_value_d;

    logic                  gnt_c;
    logic                  sel_rw_c;
    logic [ADDRESSBIT-1:0] sel_addr_c;
    logic [LW-1:0]         sel_wdata_c;

`ifdef SNOOP_RR_ARB_EN
    logic rr_ptr_q, rr_ptr_d;

    // Pointer names the cache that wins the next simultaneous request.
    always_comb begin
        gnt_c = (bus.req == 2'b11) ? rr_ptr_q : bus.req[1];
    end
`else
    always_comb begin
        gnt_c = ~bus.req[0];
    end
`endif

    always_comb begin
        sel_rw_c    = gnt_c ? bus.rw[1] : bus.rw[0];
        sel_addr_c  = gnt_c ? bus.addr[2*ADDRESSBIT-1:ADDRESSBIT] : bus.addr[ADDRESSBIT-1:0];
        sel_wdata_c = gnt_c ? bus.wdata[2*LW-1:LW] : bus.wdata[LW-1:0];
    end

    // Next state, latched request and next registered outputs.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        rw_d           = rw_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
`ifdef SNOOP_RR_ARB_EN
        rr_ptr_d       = rr_ptr_q;
`endif
        done_d         = 2'b00;
        rdata_d        = '0;
        mem_req_d      = 1'b0;
        mem_rw_d       = 1'b0;
        mem_addr_d     = '0;
        mem_data_out_d = '0;
        snoop_action_d = 4'd0;
        snoop_proc_d   = 1'b0;
        snoop_addr_d   = '0;
        snoop_value_d  = '0;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d        = SNOOP;
                    gnt_d          = gnt_c;
                    rw_d           = sel_rw_c;
                    addr_d         = sel_addr_c;
                    wdata_d        = sel_wdata_c;
`ifdef SNOOP_RR_ARB_EN
                    rr_ptr_d       = ~gnt_c;
`endif
                    snoop_action_d = sel_rw_c ? 4'd2 : 4'd1;
                    snoop_proc_d   = gnt_c;
                    snoop_addr_d   = sel_addr_c;
                    snoop_value_d  = sel_rw_c ? sel_wdata_c[WORDSIZE-1:0] : '0;
                end
            end
            SNOOP: begin
                state_d        = MEM;
                mem_req_d      = 1'b1;
                mem_rw_d       = rw_q;
                mem_addr_d     = addr_q;
                mem_data_out_d = wdata_q;
            end
            MEM: begin
                if (bus.memSuccess) begin
                    state_d = RESP;
                    done_d  = gnt_q ? 2'b10 : 2'b01;
                    rdata_d = rw_q ? '0 : bus.memDataIn;
                end else begin
                    mem_req_d      = 1'b1;
                    mem_rw_d       = rw_q;
                    mem_addr_d     = addr_q;
                    mem_data_out_d = wdata_q;
                end
            end
            RESP: begin
                // Requests seen here are ignored; re-arbitration happens in IDLE.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            gnt_q          <= 1'b0;
            rw_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
`ifdef SNOOP_RR_ARB_EN
            rr_ptr_q       <= 1'b0;
`endif
            done_q         <= 2'b00;
            rdata_q        <= '0;
            mem_req_q      <= 1'b0;
            mem_rw_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            snoop_action_q <= 4'd0;
            snoop_proc_q   <= 1'b0;
            snoop_addr_q   <= '0;
            snoop_value_q  <= '0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            rw_q           <= rw_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
`ifdef SNOOP_RR_ARB_EN
            rr_ptr_q       <= rr_ptr_d;
`endif
            done_q         <= done_d;
            rdata_q        <= rdata_d;
            mem_req_q      <= mem_req_d;
            mem_rw_q       <= mem_rw_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_out_q <= mem_data_out_d;
            snoop_action_q <= snoop_action_d;
            snoop_proc_q   <= snoop_proc_d;
            snoop_addr_q   <= snoop_addr_d;
            snoop_value_q  <= snoop_value_d;
        end
    end

    assign bus.done        = done_q;
    assign bus.rdata       = rdata_q;
    assign bus.memReq      = mem_req_q;
    assign bus.memRW       = mem_rw_q;
    assign bus.memAddr     = mem_addr_q;
    assign bus.memDataOut  = mem_data_out_q;
    assign bus.snoopAction = snoop_action_q;
    assign bus.snoopProc   = snoop_proc_q;
    assign bus.snoopAddr   = snoop_addr_q;
    assign bus.snoopValue  = snoop_value_q;

endmodule
